// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the CPU data bus, the auxiliary master, the data memory and dmem_arbiter.
// The arbiter takes the slave view; the surrounding COMPUTER level drives through the master view.
interface dmem_arbiter_if;
    logic        iCpuReadEnable;
    logic        iCpuWriteEnable;
    logic [3:0]  iCpuByteEnable;
    logic [63:0] iCpuAddress;
    logic [63:0] iCpuWriteData;
    logic [63:0] oCpuReadData;

    logic        iAuxReq;
    logic        iAuxWrite;
    logic [3:0]  iAuxByteEnable;
    logic [63:0] iAuxAddress;
    logic [63:0] iAuxWriteData;
    logic        oAuxAck;
    logic [63:0] oAuxReadData;

    logic        oMemReadEnable;
    logic        oMemWriteEnable;
    logic [3:0]  oMemByteEnable;
    logic [63:0] oMemAddress;
    logic [63:0] oMemWriteData;
    logic [63:0] iMemReadData;

    logic        oFreeze;
    logic        oBusy;

    modport slave (
        input  iCpuReadEnable, iCpuWriteEnable, iCpuByteEnable, iCpuAddress, iCpuWriteData,
        output oCpuReadData,
        input  iAuxReq, iAuxWrite, iAuxByteEnable, iAuxAddress, iAuxWriteData,
        output oAuxAck, oAuxReadData,
        output oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
        input  iMemReadData,
        output oFreeze, oBusy
    );

    modport master (
        output iCpuReadEnable, iCpuWriteEnable, iCpuByteEnable, iCpuAddress, iCpuWriteData,
        input  oCpuReadData,
        output iAuxReq, iAuxWrite, iAuxByteEnable, iAuxAddress, iAuxWriteData,
        input  oAuxAck, oAuxReadData,
        input  oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
        output iMemReadData,
        input  oFreeze, oBusy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (always preferred) and one auxiliary master.
// A starved aux request freezes the CPU clock for two cycles and forces its access through.
module dmem_arbiter #(
    parameter int MAX_WAIT = 16,
    parameter int READ_LAT = 1
) (
    input logic           iCLK,
    input logic           iRST,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FREEZE,
        S_ISSUE,
        S_RDWAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [2:0] RD_LAST   = 3'(READ_LAT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic [2:0]  rd_cnt;
    logic        aux_write_q;
    logic [3:0]  aux_be_q;
    logic [63:0] aux_addr_q;
    logic [63:0] aux_wdata_q;
    logic [63:0] aux_rdata_q;
    logic        freeze_q;
    logic        cpu_busy;
    logic        aux_owns_bus;
    logic        aux_start;
    logic        rd_last;

    assign cpu_busy  = bus.iCpuReadEnable | bus.iCpuWriteEnable;
    assign aux_start = (state == S_IDLE) && bus.iAuxReq;
    assign rd_last   = (state == S_RDWAIT) && (rd_cnt == RD_LAST);

    // A CPU-idle cycle in WAIT wins over the starvation check, so a late grant never freezes.
    always_comb begin
        next_state   = state;
        aux_owns_bus = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.iAuxReq) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cpu_busy) begin
                    aux_owns_bus = 1'b1;
                    next_state   = aux_write_q ? S_DONE : S_RDWAIT;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_FREEZE;
                end
            end
            S_FREEZE: begin
                next_state = S_ISSUE;
            end
            S_ISSUE: begin
                aux_owns_bus = 1'b1;
                next_state   = aux_write_q ? S_DONE : S_RDWAIT;
            end
            S_RDWAIT: begin
                if (rd_last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= S_IDLE;
            freeze_q <= 1'b0;
        end else begin
            state    <= next_state;
            freeze_q <= (next_state == S_FREEZE) || (next_state == S_ISSUE);
        end
    end

    // Aux fields are sampled once on acceptance; later changes on the aux inputs are ignored.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            aux_write_q <= 1'b0;
            aux_be_q    <= 4'h0;
            aux_addr_q  <= 64'h0;
            aux_wdata_q <= 64'h0;
        end else if (aux_start) begin
            aux_write_q <= bus.iAuxWrite;
            aux_be_q    <= bus.iAuxByteEnable;
            aux_addr_q  <= bus.iAuxAddress;
            aux_wdata_q <= bus.iAuxWriteData;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wait_cnt <= 8'h00;
        end else if (aux_start) begin
            wait_cnt <= 8'h00;
        end else if ((state == S_WAIT) && cpu_busy && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'h01;
        end
    end

    // rd_cnt runs from 0 in the first cycle after issue; the last count lines up with valid data.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_cnt      <= 3'h0;
            aux_rdata_q <= 64'h0;
        end else begin
            rd_cnt <= (state == S_RDWAIT) ? rd_cnt + 3'h1 : 3'h0;
            if (rd_last) begin
                aux_rdata_q <= bus.iMemReadData;
            end
        end
    end

    assign bus.oMemReadEnable  = aux_owns_bus ? ~aux_write_q : bus.iCpuReadEnable;
    assign bus.oMemWriteEnable = aux_owns_bus ? aux_write_q  : bus.iCpuWriteEnable;
    assign bus.oMemByteEnable  = aux_owns_bus ? aux_be_q     : bus.iCpuByteEnable;
    assign bus.oMemAddress     = aux_owns_bus ? aux_addr_q   : bus.iCpuAddress;
    assign bus.oMemWriteData   = aux_owns_bus ? aux_wdata_q  : bus.iCpuWriteData;

    assign bus.oCpuReadData = bus.iMemReadData;
    assign bus.oAuxReadData = aux_rdata_q;
    assign bus.oAuxAck      = (state == S_DONE);
    assign bus.oBusy        = (state != S_IDLE);
    assign bus.oFreeze      = freeze_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level timeline model.
module tb_dmem_arbiter;
    localparam int MW   = 4;
    localparam int RL   = 2;
    localparam int NCYC = 4000;

    typedef struct {
        logic        re;
        logic        we;
        logic [3:0]  be;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        exp_re;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [63:0] exp_addr;
        logic [63:0] exp_wd;
    } vec_t;

    typedef struct {
        int          s;
        int          g;
        int          a;
        logic        wr;
        logic [3:0]  be;
        logic [63:0] addr;
        logic [63:0] wd;
    } txn_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   total = 0;
    int   bad = 0;

    txn_t txq[$];
    bit   busy_arr [NCYC];
    bit   req_arr  [NCYC];
    bit   bsy_arr  [NCYC];
    bit   frz_arr  [NCYC];
    int   start_idx[NCYC];
    int   own_idx  [NCYC];
    int   ack_idx  [NCYC];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_WAIT(MW), .READ_LAT(RL)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    always #5 iCLK = ~iCLK;

    // Pipelined memory: data for a read issued in cycle t is valid during cycle t+RL.
    function automatic logic [63:0] mem_value(input logic [63:0] a);
        if (a == 64'h200) return 64'h1234;
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_0000_FFFF_1111;
    endfunction

    logic [63:0] rd_pipe [RL];
    always @(posedge iCLK) begin
        rd_pipe[0] <= bus.oMemReadEnable ? mem_value(bus.oMemAddress) : 64'h5A5A_5A5A_5A5A_5A5A;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i - 1];
    end
    assign bus.iMemReadData = rd_pipe[RL - 1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cre, input logic cwe, input logic [3:0] cbe,
                                 input logic [63:0] caddr, input logic [63:0] cwd,
                                 input logic areq, input logic awr, input logic [3:0] abe,
                                 input logic [63:0] aaddr, input logic [63:0] awd);
        bus.iCpuReadEnable  = cre;
        bus.iCpuWriteEnable = cwe;
        bus.iCpuByteEnable  = cbe;
        bus.iCpuAddress     = caddr;
        bus.iCpuWriteData   = cwd;
        bus.iAuxReq         = areq;
        bus.iAuxWrite       = awr;
        bus.iAuxByteEnable  = abe;
        bus.iAuxAddress     = aaddr;
        bus.iAuxWriteData   = awd;
    endtask

    task automatic step_cycle();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic re, input logic we, input logic [3:0] be,
                             input logic [63:0] addr, input logic [63:0] wd);
        checkOutput({tag, " mem_re"}, bus.oMemReadEnable, re);
        checkOutput({tag, " mem_we"}, bus.oMemWriteEnable, we);
        checkOutput({tag, " mem_be"}, bus.oMemByteEnable, be);
        checkOutput({tag, " mem_addr"}, bus.oMemAddress, addr);
        checkOutput({tag, " mem_wd"}, bus.oMemWriteData, wd);
    endtask

    task automatic apply_reset();
        iRST = 1'b1;
        applyStimulus(0, 0, 4'h0, 64'h0, 64'h0, 0, 0, 4'h0, 64'h0, 64'h0);
        repeat (2) @(posedge iCLK);
        #1;
        applyStimulus(1, 0, 4'h3, 64'h88, 64'h77, 0, 0, 4'h0, 64'h0, 64'h0);
        @(negedge iCLK);
        checkOutput("rst ack", bus.oAuxAck, 1'b0);
        checkOutput("rst freeze", bus.oFreeze, 1'b0);
        checkOutput("rst busy", bus.oBusy, 1'b0);
        checkOutput("rst auxrd", bus.oAuxReadData, 64'h0);
        check_bus("rst", 1, 0, 4'h3, 64'h88, 64'h77);
        step_cycle();
        iRST = 1'b0;
    endtask

    task automatic run_table();
        vec_t vecs [6];
        vecs[0] = '{1, 0, 4'hF, 64'h1000, 64'h0, 1, 0, 4'hF, 64'h1000, 64'h0};
        vecs[1] = '{0, 1, 4'h3, 64'h2008, 64'h1111_2222_3333_4444, 0, 1, 4'h3, 64'h2008, 64'h1111_2222_3333_4444};
        vecs[2] = '{0, 1, 4'hC, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF,
                    0, 1, 4'hC, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{1, 0, 4'h1, 64'h0, 64'hABCD, 1, 0, 4'h1, 64'h0, 64'hABCD};
        vecs[4] = '{0, 0, 4'h0, 64'h55, 64'h66, 0, 0, 4'h0, 64'h55, 64'h66};
        vecs[5] = '{1, 1, 4'hA, 64'h8000_0000_0000_0000, 64'h1, 1, 1, 4'hA, 64'h8000_0000_0000_0000, 64'h1};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].re, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd,
                          0, 1, 4'h5, 64'hDEAD, 64'hBEEF);
            @(negedge iCLK);
            check_bus("tbl", vecs[i].exp_re, vecs[i].exp_we, vecs[i].exp_be, vecs[i].exp_addr, vecs[i].exp_wd);
            checkOutput("tbl busy", bus.oBusy, 1'b0);
            checkOutput("tbl freeze", bus.oFreeze, 1'b0);
            step_cycle();
        end
    endtask

    task automatic run_write_idle();
        applyStimulus(0, 0, 4'h0, 64'h0, 64'h0, 1, 1, 4'hF, 64'h100, 64'hDEADBEEF_00000001);
        @(negedge iCLK);
        checkOutput("wr c0 ack", bus.oAuxAck, 1'b0);
        step_cycle();
        applyStimulus(0, 0, 4'h0, 64'h0, 64'h0, 1, 0, 4'h3, 64'h999, 64'h1);
        @(negedge iCLK);
        check_bus("wr c1", 0, 1, 4'hF, 64'h100, 64'hDEADBEEF_00000001);
        checkOutput("wr c1 ack", bus.oAuxAck, 1'b0);
        checkOutput("wr c1 freeze", bus.oFreeze, 1'b0);
        step_cycle();
        applyStimulus(0, 0, 4'h0, 64'h0, 64'h0, 0, 0, 4'h0, 64'h0, 64'h0);
        @(negedge iCLK);
        checkOutput("wr c2 ack", bus.oAuxAck, 1'b1);
        checkOutput("wr c2 freeze", bus.oFreeze, 1'b0);
        step_cycle();
        @(negedge iCLK);
        checkOutput("wr c3 ack", bus.oAuxAck, 1'b0);
        checkOutput("wr c3 busy", bus.oBusy, 1'b0);
        step_cycle();
    endtask

    task automatic run_read_latency();
        for (int c = 0; c <= 4; c++) begin
            if (c == 0) applyStimulus(0, 0, 4'h0, 64'h0, 64'h0, 1, 0, 4'hF, 64'h200, 64'h0);
            else        applyStimulus(0, 0, 4'h0, 64'h0, 64'h0, c < 4, 1, 4'h1, 64'h777, 64'h9);
            @(negedge iCLK);
            checkOutput("rd ack", bus.oAuxAck, c == 4);
            if (c == 1) check_bus("rd c1", 1, 0, 4'hF, 64'h200, 64'h0);
            if (c == 3) checkOutput("rd c3 auxrd", bus.oAuxReadData, 64'h0);
            if (c == 4) checkOutput("rd c4 auxrd", bus.oAuxReadData, 64'h1234);
            step_cycle();
        end
    endtask

    task automatic run_starvation();
        for (int c = 0; c <= 7; c++) begin
            if (c == 0) applyStimulus(1, 0, 4'h1, 64'h40, 64'h0, 1, 1, 4'hC, 64'h300, 64'hCAFE_0000_F00D);
            else        applyStimulus(1, 0, 4'h1, 64'h40 + 64'(c), 64'h0, c < 7, 0, 4'h2, 64'h555, 64'h3);
            @(negedge iCLK);
            checkOutput("stv freeze", bus.oFreeze, (c == 5) || (c == 6));
            checkOutput("stv ack", bus.oAuxAck, c == 7);
            if (c == 6) check_bus("stv issue", 0, 1, 4'hC, 64'h300, 64'hCAFE_0000_F00D);
            else        check_bus("stv cpu", 1, 0, 4'h1, 64'h40 + 64'(c), 64'h0);
            step_cycle();
        end
    endtask

    task automatic run_late_grant(input int nbusy);
        int g;
        g = 1 + nbusy;
        for (int c = 0; c <= g + 2; c++) begin
            applyStimulus(0, c <= nbusy, 4'h6, 64'h60 + 64'(c), 64'h70,
                          c <= g, c == 0, 4'h9, (c == 0) ? 64'h400 : 64'h444, 64'h5151);
            @(negedge iCLK);
            checkOutput("late freeze", bus.oFreeze, 1'b0);
            checkOutput("late ack", bus.oAuxAck, c == g + 1);
            if (c == g) check_bus("late grant", 0, 1, 4'h9, 64'h400, 64'h5151);
            else        check_bus("late cpu", 0, c <= nbusy, 4'h6, 64'h60 + 64'(c), 64'h70);
            step_cycle();
        end
    endtask

    task automatic run_reset_in_issue();
        for (int c = 0; c <= 8; c++) begin
            applyStimulus(1, 0, 4'h1, 64'h80, 64'h0, c <= 6, 0, 4'hF, 64'h520, 64'h0);
            iRST = (c == 6);
            @(negedge iCLK);
            if (c == 6) begin
                checkOutput("rsti freeze", bus.oFreeze, 1'b1);
                checkOutput("rsti auxrd before", bus.oAuxReadData, 64'h1234);
                check_bus("rsti issue", 1, 0, 4'hF, 64'h520, 64'h0);
            end
            if (c >= 7) begin
                checkOutput("rsti ack", bus.oAuxAck, 1'b0);
                checkOutput("rsti freeze after", bus.oFreeze, 1'b0);
                checkOutput("rsti busy", bus.oBusy, 1'b0);
                checkOutput("rsti auxrd", bus.oAuxReadData, 64'h0);
            end
            step_cycle();
        end
        iRST = 1'b0;
    endtask

    task automatic run_random();
        txn_t        tx;
        int          t, idx, level;
        bit          forced;
        logic        cre, cwe, awr;
        logic [3:0]  cbe, abe;
        logic [63:0] caddr, cwd, aaddr, awd, exp_rd;
        level = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (c % 40 == 0) level = $urandom_range(0, 10);
            busy_arr[c]  = ($urandom_range(0, 9) < level);
            req_arr[c]   = 0;
            bsy_arr[c]   = 0;
            frz_arr[c]   = 0;
            start_idx[c] = -1;
            own_idx[c]   = -1;
            ack_idx[c]   = -1;
        end
        t = 3;
        while (t + MW + RL + 8 < NCYC) begin
            tx.wr   = 1'($urandom_range(0, 1));
            tx.be   = 4'($urandom);
            tx.addr = {$urandom, $urandom};
            tx.wd   = {$urandom, $urandom};
            tx.s    = t;
            forced  = 1;
            tx.g    = t + MW + 2;
            for (int k = 0; k < MW; k++) begin
                if (!busy_arr[t + 1 + k]) begin
                    tx.g   = t + 1 + k;
                    forced = 0;
                    break;
                end
            end
            tx.a = tx.g + 1 + (tx.wr ? 0 : RL);
            idx  = txq.size();
            txq.push_back(tx);
            start_idx[t]   = idx;
            own_idx[tx.g]  = idx;
            ack_idx[tx.a]  = idx;
            for (int c = tx.s; c < tx.a; c++) req_arr[c] = 1;
            for (int c = tx.s + 1; c <= tx.a; c++) bsy_arr[c] = 1;
            if (forced) begin
                frz_arr[tx.g - 1] = 1;
                frz_arr[tx.g]     = 1;
            end
            t = tx.a + 1 + $urandom_range(0, 3);
        end

        exp_rd = 64'h0;
        for (int c = 0; c < NCYC; c++) begin
            cre   = busy_arr[c] ? 1'($urandom_range(0, 1)) : 1'b0;
            cwe   = busy_arr[c] ? ~cre : 1'b0;
            cbe   = 4'($urandom);
            caddr = {$urandom, $urandom};
            cwd   = {$urandom, $urandom};
            if (start_idx[c] >= 0) begin
                awr   = txq[start_idx[c]].wr;
                abe   = txq[start_idx[c]].be;
                aaddr = txq[start_idx[c]].addr;
                awd   = txq[start_idx[c]].wd;
            end else begin
                awr   = 1'($urandom_range(0, 1));
                abe   = 4'($urandom);
                aaddr = {$urandom, $urandom};
                awd   = {$urandom, $urandom};
            end
            applyStimulus(cre, cwe, cbe, caddr, cwd, req_arr[c], awr, abe, aaddr, awd);
            @(negedge iCLK);
            if (ack_idx[c] >= 0 && !txq[ack_idx[c]].wr) exp_rd = mem_value(txq[ack_idx[c]].addr);
            checkOutput("rnd ack", bus.oAuxAck, ack_idx[c] >= 0);
            checkOutput("rnd freeze", bus.oFreeze, frz_arr[c]);
            checkOutput("rnd busy", bus.oBusy, bsy_arr[c]);
            checkOutput("rnd auxrd", bus.oAuxReadData, exp_rd);
            checkOutput("rnd cpurd", bus.oCpuReadData, bus.iMemReadData);
            if (own_idx[c] >= 0)
                check_bus("rnd aux", ~txq[own_idx[c]].wr, txq[own_idx[c]].wr, txq[own_idx[c]].be,
                          txq[own_idx[c]].addr, txq[own_idx[c]].wd);
            else
                check_bus("rnd cpu", cre, cwe, cbe, caddr, cwd);
            step_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] dmem_arbiter bench start, MAX_WAIT=%0d READ_LAT=%0d", MW, RL);
        apply_reset();
        run_table();
        run_write_idle();
        run_read_latency();
        run_starvation();
        run_late_grant(2);
        run_late_grant(MW - 1);
        run_reset_in_issue();
        apply_reset();
        run_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
